// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the data memory controller.
//   - Access size encodings carried on req_size (byte / half / word / reserved).
//   - Controller FSM state type.
//   - misaligned(): alignment rule for a given size and low address bits.
package mem_pkg;

    localparam logic [1:0] SZ_B    = 2'b00;
    localparam logic [1:0] SZ_H    = 2'b01;
    localparam logic [1:0] SZ_W    = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Reserved size is reported as misaligned so it folds into the error path.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lo[0];
            SZ_W:    bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: combinational little-endian lane formatting.
//   size, ld_unsigned : access size and load extension mode
//   lane              : addr[1:0] of the access
//   st_data           : right-aligned store data
//   rd_word           : 32-bit word currently held in storage
//   byte_en           : per-byte write enables for the store
//   st_word           : store data replicated onto every candidate lane
//   ld_data           : extracted and extended load result
module dmem_lane
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    input  logic [1:0]  lane,
    input  logic [31:0] st_data,
    input  logic [31:0] rd_word,
    output logic [3:0]  byte_en,
    output logic [31:0] st_word,
    output logic [31:0] ld_data
);

    logic        [7:0]  ld_byte;
    logic        [15:0] ld_half;
    logic signed [31:0] ld_byte_sx;
    logic signed [31:0] ld_half_sx;

    always_comb begin
        ld_byte    = rd_word[{lane, 3'b000} +: 8];
        ld_half    = lane[1] ? rd_word[31:16] : rd_word[15:0];
        ld_byte_sx = {{24{ld_byte[7]}}, ld_byte};
        ld_half_sx = {{16{ld_half[15]}}, ld_half};
    end

    // Store data is replicated across lanes; byte_en alone picks what lands.
    always_comb begin
        byte_en = 4'b0000;
        st_word = '0;
        ld_data = '0;
        case (size)
            SZ_B: begin
                byte_en = 4'b0001 << lane;
                st_word = {4{st_data[7:0]}};
                ld_data = ld_unsigned ? {24'b0, ld_byte} : ld_byte_sx;
            end
            SZ_H: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                st_word = {2{st_data[15:0]}};
                ld_data = ld_unsigned ? {16'b0, ld_half} : ld_half_sx;
            end
            SZ_W: begin
                byte_en = 4'b1111;
                st_word = st_data;
                ld_data = rd_word;
            end
            default: begin
                byte_en = 4'b0000;
                st_word = '0;
                ld_data = '0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-outstanding data memory controller with
// configurable access latency and byte/half/word loads and stores.
//   clk, reset (async, active-low)
//   req_valid/req_ready   : request handshake; req_ready high only when idle
//   req_we, req_size, req_unsigned, req_addr, req_wdata : request fields
//   rsp_valid/rsp_ready   : response handshake; response held until taken
//   rsp_rdata, rsp_err    : load result (0 on store/error) and error flag
// Storage is not reset. Stores commit and loads sample storage on the edge
// that enters RESP, so a request abandoned by reset never writes.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [2:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    state_t      state, state_nx;
    logic [2:0]  cnt, cnt_nx;
    logic        accept;
    logic        enter_resp;

    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    // Active request: live inputs while idle (needed for the zero-wait path,
    // where the accepting edge is also the RESP-entry edge), latched otherwise.
    logic        a_we;
    logic [1:0]  a_size;
    logic        a_uns;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_err;
    logic [AW-1:0] idx;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_word;
    logic [3:0]  byte_en;
    logic [31:0] st_word;
    logic [31:0] ld_data;

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid & req_ready;

    always_comb begin
        if (state == S_IDLE) begin
            a_we    = req_we;
            a_size  = req_size;
            a_uns   = req_unsigned;
            a_addr  = req_addr;
            a_wdata = req_wdata;
        end else begin
            a_we    = we_q;
            a_size  = size_q;
            a_uns   = uns_q;
            a_addr  = addr_q;
            a_wdata = wdata_q;
        end
    end

    // Any address bit above the word index means the word is out of range.
    assign a_err   = misaligned(a_size, a_addr[1:0]) | (a_addr[31:AW+2] != '0);
    assign idx     = a_addr[AW+1:2];
    assign rd_word = mem[idx];

    dmem_lane u_lane (
        .size        (a_size),
        .ld_unsigned (a_uns),
        .lane        (a_addr[1:0]),
        .st_data     (a_wdata),
        .rd_word     (rd_word),
        .byte_en     (byte_en),
        .st_word     (st_word),
        .ld_data     (ld_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        enter_resp = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nx   = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nx = S_WAIT;
                        cnt_nx   = 3'd0;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == WAIT_LAST) begin
                    state_nx   = S_RESP;
                    enter_resp = 1'b1;
                    cnt_nx     = 3'd0;
                end else begin
                    cnt_nx = cnt + 3'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else if (enter_resp) begin
            rsp_valid <= 1'b1;
            rsp_err   <= a_err;
            rsp_rdata <= (a_err || a_we) ? 32'd0 : ld_data;
        end else if (state == S_RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (enter_resp && a_we && !a_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[idx][8*b +: 8] <= st_word[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed bench for data_mem_ctrl (DEPTH_WORDS=64,
// WAIT_CYCLES=2). Expected responses are queued when a request is issued and
// popped when the controller presents its response.
module tb_data_mem_ctrl;
    import mem_pkg::*;

    localparam int DEPTH = 64;
    localparam int WAITC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       tag;
    } exp_t;

    exp_t sb[$];

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.tag   = tag;
        sb.push_back(e);
    endtask

    // Presents a request and returns #1 after the accepting edge.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        int n = 0;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        while (req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_ready_at_issue", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    // Counts edges from the accepting edge (which is edge 1) to rsp_valid.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic wait_rsp();
        int   lat;
        exp_t e;
        wait_valid(lat);
        chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, "_latency"}, 32'(lat), 32'(WAITC + 1));
            chk({e.tag, "_rdata"}, rsp_rdata, e.rdata);
            chk({e.tag, "_err"}, 32'(rsp_err), 32'(e.err));
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic xact(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rdata, input logic exp_err);
        push_exp(tag, exp_rdata, exp_err);
        issue(we, sz, uns, addr, wd);
        wait_rsp();
        consume();
    endtask

    initial begin
        int lat;
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = SZ_W;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        rsp_ready    = 1'b0;

        tick();
        tick();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        reset = 1'b1;
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        // word store/load with latency check
        xact("sw_dead", 1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        xact("lw_dead", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // byte and half lanes, sign/zero extension
        xact("sw_1122", 1'b1, SZ_W, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0);
        xact("sb_aa",   1'b1, SZ_B, 1'b0, 32'h12, 32'hFFFFFFAA, 32'h0, 1'b0);
        xact("lw_11aa", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h11AA3344, 1'b0);
        xact("lb_12",   1'b0, SZ_B, 1'b0, 32'h12, 32'h0, 32'hFFFFFFAA, 1'b0);
        xact("lbu_12",  1'b0, SZ_B, 1'b1, 32'h12, 32'h0, 32'h000000AA, 1'b0);
        xact("lb_13",   1'b0, SZ_B, 1'b0, 32'h13, 32'h0, 32'h00000011, 1'b0);
        xact("sh_8001", 1'b1, SZ_H, 1'b0, 32'h10, 32'h55558001, 32'h0, 1'b0);
        xact("lw_8001", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h11AA8001, 1'b0);
        xact("lh_10",   1'b0, SZ_H, 1'b0, 32'h10, 32'h0, 32'hFFFF8001, 1'b0);
        xact("lhu_10",  1'b0, SZ_H, 1'b1, 32'h10, 32'h0, 32'h00008001, 1'b0);
        xact("lh_12",   1'b0, SZ_H, 1'b0, 32'h12, 32'h0, 32'h000011AA, 1'b0);
        xact("lb_11",   1'b0, SZ_B, 1'b0, 32'h11, 32'h0, 32'hFFFFFF80, 1'b0);

        // misalignment errors, no write on error
        xact("sw_0c",    1'b1, SZ_W, 1'b0, 32'h0C, 32'hCAFEF00D, 32'h0, 1'b0);
        xact("lh_11",    1'b0, SZ_H, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1);
        xact("sw_0e",    1'b1, SZ_W, 1'b0, 32'h0E, 32'h00000055, 32'h0, 1'b1);
        xact("lw_0c",    1'b0, SZ_W, 1'b0, 32'h0C, 32'h0, 32'hCAFEF00D, 1'b0);

        // range and reserved-size errors; last word is in range
        xact("sw_00",    1'b1, SZ_W, 1'b0, 32'h00, 32'hA5A5A5A5, 32'h0, 1'b0);
        xact("lw_100",   1'b0, SZ_W, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
        xact("sw_100",   1'b1, SZ_W, 1'b0, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b1);
        xact("lw_00",    1'b0, SZ_W, 1'b0, 32'h00, 32'h0, 32'hA5A5A5A5, 1'b0);
        xact("sz_rsvd",  1'b0, SZ_RSVD, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
        xact("sw_fc",    1'b1, SZ_W, 1'b0, 32'hFC, 32'h13579BDF, 32'h0, 1'b0);
        xact("lw_fc",    1'b0, SZ_W, 1'b0, 32'hFC, 32'h0, 32'h13579BDF, 1'b0);

        // response backpressure with a competing request held on the bus
        push_exp("bp_lw", 32'h11AA8001, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
        wait_rsp();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = SZ_W;
        req_addr  = 32'h10;
        req_wdata = 32'h0BAD0BAD;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_rdata", rsp_rdata, 32'h11AA8001);
            chk("bp_rsp_err", 32'(rsp_err), 32'd0);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        req_we    = 1'b0;
        consume();
        chk("bp_idle_ready", 32'(req_ready), 32'd1);
        xact("bp_after", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h11AA8001, 1'b0);

        // reset during WAIT abandons an uncommitted store
        xact("sw_20", 1'b1, SZ_W, 1'b0, 32'h20, 32'h11111111, 32'h0, 1'b0);
        issue(1'b1, SZ_W, 1'b0, 32'h20, 32'h12345678);
        chk("wait_req_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("wrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("wrst_rsp_err", 32'(rsp_err), 32'd0);
        chk("wrst_rsp_rdata", rsp_rdata, 32'd0);
        chk("wrst_req_ready", 32'(req_ready), 32'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        xact("lw_20", 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);

        // reset while a load response is being presented
        issue(1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
        wait_valid(lat);
        chk("rrst_pre_valid", 32'(rsp_valid), 32'd1);
        chk("rrst_pre_rdata", rsp_rdata, 32'h11AA8001);
        reset = 1'b0;
        #1;
        chk("rrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rrst_rsp_rdata", rsp_rdata, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("rrst_req_ready", 32'(req_ready), 32'd1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
